button_press_classifier: RTL

- Sits directly downstream of the button debouncer and consumes its clean, clock-synchronous `debounced` level.
- Classifies each physical button gesture into exactly one event: short press, long press or double press. Each event is a single-cycle pulse.
- Also exports a registered `pressed` level and a `busy` flag for the control FSM and UI logic.

---
 rtl/button_pkg.sv | 17 +
 rtl/rise_edge_detect.sv | 35 +++
 rtl/button_press_classifier.sv | 113 +++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared state encoding for the button handling blocks
// (debouncer, press classifier, UI FSM).
package button_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PRESS1 = 3'd1;
    localparam logic [2:0] WAIT2  = 3'd2;
    localparam logic [2:0] PRESS2 = 3'd3;
    localparam logic [2:0] HELD   = 3'd4;

    function automatic logic is_busy(input state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Registers a synchronous level once and flags its rising edge.
// PREV_RESET=1 makes a level already high at reset look like "no edge".
module rise_edge_detect #(
    parameter logic PREV_RESET = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic level_q
);

    logic prev_q;
    logic prev_d;
    logic level_d;

    always_comb begin
        prev_d  = level;
        level_d = level;
    end

    assign rise = level & ~prev_q;

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= PREV_RESET;
            level_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/button_press_classifier.sv
// Classifies each debounced button gesture as a short, long or double press,
// emitting one registered single-cycle pulse per gesture.
module button_press_classifier
    import button_pkg::*;
#(
    parameter int LONG_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 25_000_000,
    parameter int CNT_W       = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic debounced,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             rise;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;

    rise_edge_detect #(
        .PREV_RESET (1'b1)
    ) u_edge (
        .clk     (clk),
        .rst     (rst),
        .level   (debounced),
        .rise    (rise),
        .level_q (pressed)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS1;
                    cnt_d   = '0;
                end
            end
            PRESS1: begin
                if (!debounced) begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT2: begin
                // A second press wins even on the final edge of the gap window.
                if (rise) begin
                    state_d = PRESS2;
                end else if (cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESS2: begin
                if (!debounced) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            HELD: begin
                if (!debounced) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign busy         = is_busy(state_q);

endmodule
